// File: rtl/proc_ctrl_seq.sv
// proc_ctrl_seq: multi-cycle control sequencer for one distributed-processor core.
// Decodes the opcode class and steps the ALU, register file, instruction pointer,
// qclk load, pulse strobe, fproc handshake and sync barrier.
module proc_ctrl_seq #(
  parameter int ALU_LATENCY   = 1,
  parameter int FPROC_TIMEOUT = 0,
  parameter int TO_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic       fproc_ready,
  input  logic       sync_enable,
  input  logic       cstrobe_in,
  output logic [2:0] alu_opcode,
  output logic       alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic       reg_write_en,
  output logic       instr_ptr_en,
  output logic [1:0] instr_ptr_load_en,
  output logic       qclk_load_en,
  output logic       c_strobe_enable,
  output logic       sync_out_ready,
  output logic       fproc_out_ready,
  output logic       halted,
  output logic [1:0] err
);

  // State encoding
  localparam logic [3:0] ST_INIT            = 4'd0;
  localparam logic [3:0] ST_ALU_WAIT        = 4'd1;
  localparam logic [3:0] ST_ALU_COMMIT      = 4'd2;
  localparam logic [3:0] ST_QCLK_COMMIT     = 4'd3;
  localparam logic [3:0] ST_JCOND_COMMIT    = 4'd4;
  localparam logic [3:0] ST_ALU_FPROC_WAIT  = 4'd5;
  localparam logic [3:0] ST_JUMP_FPROC_WAIT = 4'd6;
  localparam logic [3:0] ST_SYNC_WAIT       = 4'd7;
  localparam logic [3:0] ST_HALT            = 4'd8;

  // Opcode classes (opcode[7:4])
  localparam logic [3:0] CL_PULSE_I    = 4'd0;
  localparam logic [3:0] CL_REG_ALU    = 4'd1;
  localparam logic [3:0] CL_JUMP_I     = 4'd2;
  localparam logic [3:0] CL_JUMP_COND  = 4'd3;
  localparam logic [3:0] CL_INC_QCLK   = 4'd4;
  localparam logic [3:0] CL_ALU_FPROC  = 4'd5;
  localparam logic [3:0] CL_JUMP_FPROC = 4'd6;
  localparam logic [3:0] CL_SYNC       = 4'd7;
  localparam logic [3:0] CL_HALT       = 4'd8;

  // ALU input 1 sources
  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_QCLK  = 2'd1;
  localparam logic [1:0] SEL_FPROC = 2'd2;

  // The first ALU_WAIT cycle holds ALU_LATENCY-1; leaving at 1 gives exactly
  // ALU_LATENCY cycles from operand select to commit.
  localparam logic [3:0]          LAT_LOAD = 4'(ALU_LATENCY - 1);
  localparam bit                  LAT_ONE  = (ALU_LATENCY == 1);
  localparam bit                  TO_EN    = (FPROC_TIMEOUT != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(FPROC_TIMEOUT - 1);

  logic [3:0]          state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic [3:0]          tgt_q, tgt_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          err_q, err_d;

  logic       ce_c, ipe_c, rwe_c, qle_c, sor_c, fpr_c, hlt_c;
  logic [1:0] ipl_c;
  logic       start_alu;
  logic [3:0] start_tgt;
  logic [3:0] op_class;

  assign op_class    = opcode[7:4];
  assign alu_opcode  = opcode[2:0];
  assign alu_in0_sel = opcode[3];

  // Next-state and output decode from the current state and opcode class.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    tgt_d     = tgt_q;
    to_d      = to_q;
    sel_d     = sel_q;
    err_d     = err_q;
    ce_c      = 1'b0;
    ipe_c     = 1'b0;
    ipl_c     = 2'd0;
    rwe_c     = 1'b0;
    qle_c     = 1'b0;
    sor_c     = 1'b0;
    fpr_c     = 1'b0;
    hlt_c     = 1'b0;
    start_alu = 1'b0;
    start_tgt = ST_ALU_COMMIT;
    case (state_q)
      ST_INIT: begin
        case (op_class)
          CL_PULSE_I: begin
            ce_c  = 1'b1;
            ipe_c = cstrobe_in;
          end
          CL_REG_ALU: begin
            sel_d     = SEL_REG;
            start_alu = 1'b1;
            start_tgt = ST_ALU_COMMIT;
          end
          CL_JUMP_I: begin
            ipe_c = 1'b1;
            ipl_c = 2'd1;
          end
          CL_JUMP_COND: begin
            sel_d     = SEL_REG;
            start_alu = 1'b1;
            start_tgt = ST_JCOND_COMMIT;
          end
          CL_INC_QCLK: begin
            sel_d     = SEL_QCLK;
            start_alu = 1'b1;
            start_tgt = ST_QCLK_COMMIT;
          end
          CL_ALU_FPROC: begin
            fpr_c   = 1'b1;
            to_d    = '0;
            state_d = ST_ALU_FPROC_WAIT;
          end
          CL_JUMP_FPROC: begin
            fpr_c   = 1'b1;
            to_d    = '0;
            state_d = ST_JUMP_FPROC_WAIT;
          end
          CL_SYNC: state_d = ST_SYNC_WAIT;
          CL_HALT: state_d = ST_HALT;
          default: begin
            err_d[1] = 1'b1;
            state_d  = ST_HALT;
          end
        endcase
      end
      ST_ALU_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d = tgt_q;
        end
      end
      ST_ALU_COMMIT: begin
        rwe_c   = 1'b1;
        ipe_c   = 1'b1;
        state_d = ST_INIT;
      end
      ST_QCLK_COMMIT: begin
        qle_c   = 1'b1;
        ipe_c   = 1'b1;
        state_d = ST_INIT;
      end
      ST_JCOND_COMMIT: begin
        ipe_c   = 1'b1;
        ipl_c   = 2'd2;
        state_d = ST_INIT;
      end
      ST_ALU_FPROC_WAIT, ST_JUMP_FPROC_WAIT: begin
        sel_d = SEL_FPROC;
        // A ready arriving on the last allowed cycle still completes normally.
        if (fproc_ready) begin
          start_alu = 1'b1;
          start_tgt = (state_q == ST_ALU_FPROC_WAIT) ? ST_ALU_COMMIT : ST_JCOND_COMMIT;
        end else if (TO_EN) begin
          if (to_q == TO_LAST) begin
            err_d[0] = 1'b1;
            state_d  = ST_HALT;
          end else begin
            to_d = to_q + TO_WIDTH'(1);
          end
        end
      end
      ST_SYNC_WAIT: begin
        sor_c = 1'b1;
        if (sync_enable) begin
          ipe_c   = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_HALT: hlt_c = 1'b1;
      default: state_d = ST_INIT;
    endcase
    // Shared entry into the ALU pipeline from INIT or an fproc wait.
    if (start_alu) begin
      if (LAT_ONE) begin
        state_d = start_tgt;
      end else begin
        state_d = ST_ALU_WAIT;
        lat_d   = LAT_LOAD;
        tgt_d   = start_tgt;
      end
    end
  end

  // State, counters, latched ALU source and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      lat_q   <= '0;
      tgt_q   <= ST_INIT;
      to_q    <= '0;
      sel_q   <= SEL_REG;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tgt_q   <= tgt_d;
      to_q    <= to_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Enables are suppressed while reset is held so an aborted instruction never commits.
  assign alu_in1_sel       = sel_d;
  assign reg_write_en      = rwe_c & ~reset;
  assign instr_ptr_en      = ipe_c & ~reset;
  assign instr_ptr_load_en = reset ? 2'd0 : ipl_c;
  assign qclk_load_en      = qle_c & ~reset;
  assign c_strobe_enable   = ce_c & ~reset;
  assign sync_out_ready    = sor_c & ~reset;
  assign fproc_out_ready   = fpr_c & ~reset;
  assign halted            = hlt_c & ~reset;
  assign err               = err_q;

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// tb_proc_ctrl_seq: randomized bench for proc_ctrl_seq against an
// instruction-level timing model (cycle k of each instruction -> outputs).
module tb_proc_ctrl_seq;

  localparam int LAT = 3;
  localparam int TO  = 8;

  typedef struct packed {
    logic       ce;
    logic       ipe;
    logic [1:0] ipl;
    logic       rwe;
    logic       qle;
    logic       sor;
    logic       fpr;
    logic       hlt;
    logic [1:0] sel;
    logic [1:0] err;
    logic [2:0] aop;
    logic       a0;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       fproc_ready, sync_enable, cstrobe_in;
  logic [2:0] alu_opcode;
  logic       alu_in0_sel;
  logic [1:0] alu_in1_sel;
  logic       reg_write_en, instr_ptr_en;
  logic [1:0] instr_ptr_load_en;
  logic       qclk_load_en, c_strobe_enable, sync_out_ready, fproc_out_ready, halted;
  logic [1:0] err;

  always #5 clk = ~clk;

  proc_ctrl_seq #(.ALU_LATENCY(LAT), .FPROC_TIMEOUT(TO), .TO_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .fproc_ready(fproc_ready),
    .sync_enable(sync_enable), .cstrobe_in(cstrobe_in), .alu_opcode(alu_opcode),
    .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel), .reg_write_en(reg_write_en),
    .instr_ptr_en(instr_ptr_en), .instr_ptr_load_en(instr_ptr_load_en),
    .qclk_load_en(qclk_load_en), .c_strobe_enable(c_strobe_enable),
    .sync_out_ready(sync_out_ready), .fproc_out_ready(fproc_out_ready),
    .halted(halted), .err(err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  outs_t      obs;
  outs_t      obs_a[64];
  outs_t      exp_a[64];
  int         n_cyc;
  logic [1:0] m_sel;
  logic [1:0] m_err;

  // w: PULSE_I = cycles before cstrobe; fproc = wait cycle on which ready arrives;
  // SYNC = wait cycle on which sync_enable arrives.
  function automatic bit timed_out(input logic [7:0] op, input int w);
    return (op[7:4] == 4'd5 || op[7:4] == 4'd6) && (TO != 0) && (w > TO);
  endfunction

  function automatic bit ends_halted(input logic [7:0] op, input int w);
    return (op[7:4] >= 4'd8) || timed_out(op, w);
  endfunction

  function automatic int instr_len(input logic [7:0] op, input int w);
    case (op[7:4])
      4'd0:             return w + 1;
      4'd1, 4'd3, 4'd4: return 1 + LAT;
      4'd2:             return 1;
      4'd5, 4'd6:       return timed_out(op, w) ? 1 + TO : 1 + w + LAT;
      4'd7:             return 1 + w;
      default:          return 1;
    endcase
  endfunction

  // Expected outputs on cycle k (1 = first cycle) of one instruction.
  function automatic outs_t model(input logic [7:0] op, input int k, input int w,
                                  input logic [1:0] sel_in, input logic [1:0] err_in);
    outs_t e;
    int    len;
    e = '0;
    len = instr_len(op, w);
    e.aop = op[2:0];
    e.a0  = op[3];
    e.sel = sel_in;
    e.err = err_in;
    case (op[7:4])
      4'd0: begin e.ce = 1'b1; e.ipe = (k == len); end
      4'd1: begin e.sel = 2'd0; if (k == len) begin e.rwe = 1'b1; e.ipe = 1'b1; end end
      4'd2: begin e.ipe = 1'b1; e.ipl = 2'd1; end
      4'd3: begin e.sel = 2'd0; if (k == len) begin e.ipe = 1'b1; e.ipl = 2'd2; end end
      4'd4: begin e.sel = 2'd1; if (k == len) begin e.qle = 1'b1; e.ipe = 1'b1; end end
      4'd5, 4'd6: begin
        if (k == 1) e.fpr = 1'b1;
        else e.sel = 2'd2;
        if (!timed_out(op, w) && k == len) begin
          e.ipe = 1'b1;
          if (op[7:4] == 4'd5) e.rwe = 1'b1;
          else e.ipl = 2'd2;
        end
      end
      4'd7: begin
        if (k >= 2) e.sor = 1'b1;
        if (k >= 2 && k == len) e.ipe = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive_cycle(input logic [7:0] op, input logic rst, input logic cs,
                             input logic fr, input logic se);
    @(posedge clk);
    #1;
    opcode      = op;
    reset       = rst;
    cstrobe_in  = cs;
    fproc_ready = fr;
    sync_enable = se;
    @(negedge clk);
    obs = {c_strobe_enable, instr_ptr_en, instr_ptr_load_en, reg_write_en, qclk_load_en,
           sync_out_ready, fproc_out_ready, halted, alu_in1_sel, err, alu_opcode, alu_in0_sel};
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(8'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    m_sel = 2'd0;
    m_err = 2'd0;
  endtask

  // Runs one instruction plus nh trailing HALT cycles, recording observed and expected.
  task automatic run_instr(input logic [7:0] op, input int w, input int nh);
    int    len;
    outs_t e;
    len   = instr_len(op, w);
    n_cyc = 0;
    for (int k = 1; k <= len; k++) begin
      logic cs, fr, se;
      cs = 1'($urandom);
      fr = 1'($urandom);
      se = 1'($urandom);
      case (op[7:4])
        4'd0: cs = (k == len);
        4'd5, 4'd6: if (k >= 2) begin
          if (timed_out(op, w) || k < 1 + w) fr = 1'b0;
          else if (k == 1 + w) fr = 1'b1;
        end
        4'd7: if (k >= 2) se = (k == 1 + w);
        default: ;
      endcase
      drive_cycle(op, 1'b0, cs, fr, se);
      obs_a[n_cyc] = obs;
      exp_a[n_cyc] = model(op, k, w, m_sel, m_err);
      n_cyc++;
    end
    case (op[7:4])
      4'd1, 4'd3: m_sel = 2'd0;
      4'd4:       m_sel = 2'd1;
      4'd5, 4'd6: m_sel = 2'd2;
      default: ;
    endcase
    if (op[7:4] > 4'd8) m_err[1] = 1'b1;
    if (timed_out(op, w)) m_err[0] = 1'b1;
    for (int h = 0; h < nh; h++) begin
      logic [7:0] rop;
      rop = 8'($urandom);
      drive_cycle(rop, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      e = '0;
      e.hlt = 1'b1;
      e.sel = m_sel;
      e.err = m_err;
      e.aop = rop[2:0];
      e.a0  = rop[3];
      obs_a[n_cyc] = obs;
      exp_a[n_cyc] = e;
      n_cyc++;
    end
    $display("instr op=%02h w=%0d cycles=%0d halt_cycles=%0d", op, w, len, nh);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
      vectors++;
      if ({obs.ce, obs.ipe, obs.ipl, obs.rwe, obs.qle, obs.sor, obs.fpr, obs.hlt} !== 9'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h expected all enables 0", i, obs);
      end
    end
    m_sel = 2'd0;
    m_err = 2'd0;
    run_instr(8'h2A, 0, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL reset_release cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reg_alu_latency();
    run_instr(8'h12, 0, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL reg_alu_latency cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
    vectors++;
    if ({obs_a[3].rwe, obs_a[3].ipe} !== 2'b11) begin
      miscompares++;
      $display("FAIL reg_alu_commit_cycle4: got rwe,ipe=%b expected 11", {obs_a[3].rwe, obs_a[3].ipe});
    end
  endtask

  task automatic test_alu_fproc_wait();
    run_instr(8'h50, 5, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL alu_fproc_wait cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_jump_fproc_timeout();
    run_instr(8'h60, TO + 1, 2);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL fproc_timeout cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
    vectors++;
    if ({obs_a[1 + TO].hlt, obs_a[1 + TO].err} !== 3'b101) begin
      miscompares++;
      $display("FAIL timeout_halt: got halted,err=%b expected 101", {obs_a[1 + TO].hlt, obs_a[1 + TO].err});
    end
    apply_reset(1);
    run_instr(8'h60, TO, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL fproc_ready_last_cycle cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_sync_barrier();
    run_instr(8'h70, 10, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL sync_barrier cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_pulse_illegal();
    run_instr(8'h05, 3, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL pulse_i cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
    run_instr(8'hF0, 0, 3);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL illegal_class cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
    apply_reset(1);
    run_instr(8'h20, 0, 0);
    for (int i = 0; i < n_cyc; i++) begin
      vectors++;
      if (obs_a[i] !== exp_a[i]) begin
        miscompares++;
        $display("FAIL illegal_reset_release cycle %0d: got %h expected %h", i + 1, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid_instr();
    // Reset during ALU_WAIT (cycle 3), then on the commit cycle (cycle 4).
    for (int rc = 3; rc <= 4; rc++) begin
      for (int k = 1; k < rc; k++) drive_cycle(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({obs.rwe, obs.ipe} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_abort_cycle%0d: got rwe,ipe=%b expected 00", rc, {obs.rwe, obs.ipe});
      end
      drive_cycle(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({obs.ipe, obs.ipl, obs.rwe, obs.err} !== 6'b101000) begin
        miscompares++;
        $display("FAIL reset_abort_init_cycle%0d: got ipe,ipl,rwe,err=%b expected 101000", rc,
                 {obs.ipe, obs.ipl, obs.rwe, obs.err});
      end
      m_sel = 2'd0;
      m_err = 2'd0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int         c;
      int         w;
      logic [7:0] op;
      c = $urandom_range(0, 15);
      if (c > 8 && $urandom_range(0, 3) != 0) c = c - 8;
      op = {4'(c), 4'($urandom)};
      case (c)
        0:       w = $urandom_range(0, 6);
        5, 6:    w = $urandom_range(1, TO + 3);
        7:       w = $urandom_range(1, 8);
        default: w = 0;
      endcase
      run_instr(op, w, ends_halted(op, w) ? 2 : 0);
      for (int i = 0; i < n_cyc; i++) begin
        vectors++;
        if (obs_a[i] !== exp_a[i]) begin
          miscompares++;
          $display("FAIL random op=%02h w=%0d cycle %0d: got %h expected %h", op, w, i + 1, obs_a[i], exp_a[i]);
        end
      end
      if (ends_halted(op, w)) apply_reset($urandom_range(1, 2));
    end
  endtask

  initial begin
    reset       = 1'b1;
    opcode      = 8'h00;
    fproc_ready = 1'b0;
    sync_enable = 1'b0;
    cstrobe_in  = 1'b0;
    m_sel       = 2'd0;
    m_err       = 2'd0;
    test_reset();
    test_reg_alu_latency();
    test_alu_fproc_wait();
    test_jump_fproc_timeout();
    test_sync_barrier();
    test_pulse_illegal();
    test_reset_mid_instr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
